half_fp_div: RTL and testbench

HALF_FP_DIV -- requirements
Module: half_fp_div

---
 rtl/half_fp_div.sv | 208 ++++++++++++++++++++
 tb/tb_half_fp_div.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/half_fp_div.sv
// Multi-cycle IEEE-754 binary16 divider: special-case screen, 13-cycle restoring divide, round.
// Define HALF_FP_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module half_fp_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] float1,
    input  logic [15:0] float2,
    output logic [15:0] quotient,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        invalid
);

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIVIDE,
        ROUND,
        DONE
    } state_t;

    state_t state;

    logic [15:0]        op_a;
    logic [15:0]        op_b;
    logic               sign_r;
    logic signed [6:0]  exp_r;
    logic [11:0]        rem;
    logic [10:0]        divisor;
    logic [12:0]        q;
    logic [3:0]         cnt;

    // Operand field decode; exponent 0 is flushed to signed zero.
    logic        sa, sb;
    logic [4:0]  ea, eb;
    logic [9:0]  fa, fb;
    logic [10:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [6:0] exp_raw;

    always_comb begin
        sa      = op_a[15];
        sb      = op_b[15];
        ea      = op_a[14:10];
        eb      = op_b[14:10];
        fa      = op_a[9:0];
        fb      = op_b[9:0];
        ma      = {1'b1, fa};
        mb      = {1'b1, fb};
        a_zero  = (ea == 5'd0);
        b_zero  = (eb == 5'd0);
        a_inf   = (ea == 5'd31) && (fa == 10'd0);
        b_inf   = (eb == 5'd31) && (fb == 10'd0);
        a_nan   = (ea == 5'd31) && (fa != 10'd0);
        b_nan   = (eb == 5'd31) && (fb != 10'd0);
        exp_raw = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd15;
    end

    // Special-case resolution in priority order; NaN results are always the positive canonical NaN.
    logic        special_hit;
    logic [15:0] special_q;
    logic        special_dz;
    logic        special_inv;

    always_comb begin
        special_hit = 1'b1;
        special_q   = 16'h0000;
        special_dz  = 1'b0;
        special_inv = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            special_q   = 16'h7E00;
            special_inv = 1'b1;
        end else if (a_inf) begin
            special_q = {sa ^ sb, 15'h7C00};
        end else if (b_zero) begin
            special_q  = {sa ^ sb, 15'h7C00};
            special_dz = 1'b1;
        end else if (a_zero || b_inf) begin
            special_q = {sa ^ sb, 15'h0000};
        end else begin
            special_hit = 1'b0;
        end
    end

    // One restoring-division step: subtract when the partial remainder covers the divisor.
    logic        step_ge;
    logic [11:0] step_sub;
    logic [11:0] rem_next;

    always_comb begin
        step_ge  = (rem >= {1'b0, divisor});
        step_sub = rem - {1'b0, divisor};
        rem_next = step_ge ? (step_sub << 1) : (rem << 1);
    end

    // q[12] is the integer bit, q[11:2] the fraction, q[1] guard and q[0] round.
    logic              inc;
    logic [11:0]       mant_sum;
    logic [9:0]        frac_out;
    logic signed [6:0] exp_adj;
    logic [15:0]       round_q;

    always_comb begin
`ifdef HALF_FP_DIV_RNE_EN
        inc = q[1] & (q[0] | (rem != 12'd0) | q[2]);
`else
        inc = 1'b0;
`endif
        mant_sum = {1'b0, q[12:2]} + {11'd0, inc};
        frac_out = mant_sum[11] ? mant_sum[10:1] : mant_sum[9:0];
        exp_adj  = exp_r + $signed({6'd0, mant_sum[11]});
        if (exp_adj >= 7'sd31) begin
            round_q = {sign_r, 15'h7C00};
        end else if (exp_adj <= 7'sd0) begin
            round_q = {sign_r, 15'h0000};
        end else begin
            round_q = {sign_r, exp_adj[4:0], frac_out};
        end
    end

    // Datapath: operand capture, divide setup and iteration. No reset needed.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    op_a <= float1;
                    op_b <= float2;
                end
            end
            SPECIAL: begin
                sign_r  <= sa ^ sb;
                divisor <= mb;
                q       <= 13'd0;
                cnt     <= 4'd0;
                if (ma < mb) begin
                    rem   <= {ma, 1'b0};
                    exp_r <= exp_raw - 7'sd1;
                end else begin
                    rem   <= {1'b0, ma};
                    exp_r <= exp_raw;
                end
            end
            DIVIDE: begin
                rem <= rem_next;
                q   <= {q[11:0], step_ge};
                cnt <= cnt + 4'd1;
            end
            default: ;
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            quotient <= 16'h0000;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SPECIAL;
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        invalid  <= 1'b0;
                    end
                end
                SPECIAL: begin
                    if (special_hit) begin
                        state    <= DONE;
                        quotient <= special_q;
                        div_zero <= special_dz;
                        invalid  <= special_inv;
                        done     <= 1'b1;
                    end else begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (cnt == 4'd12) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    state    <= DONE;
                    quotient <= round_q;
                    done     <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_fp_div.sv
// Directed self-checking bench for half_fp_div; expectation for the rounding vector follows HALF_FP_DIV_RNE_EN.
module tb_half_fp_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] float1;
    logic [15:0] float2;
    logic [15:0] quotient;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        invalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    half_fp_div dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .float1   (float1),
        .float2   (float2),
        .quotient (quotient),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .invalid  (invalid)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Latency counts cycles after the start edge: the cycle following that edge is cycle 1.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] q, output logic dz, output logic inv,
                                 output int lat);
        @(negedge clk);
        float1 = a;
        float2 = b;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) checkOutput("done_timeout", {15'd0, done}, 16'd1);
        q   = quotient;
        dz  = div_zero;
        inv = invalid;
    endtask

    task automatic runVector(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp_q, input logic exp_dz, input logic exp_inv,
                             input int exp_lat);
        logic [15:0] q;
        logic        dz, inv;
        int          lat;
        applyStimulus(a, b, q, dz, inv, lat);
        checkOutput({tag, "_q"}, q, exp_q);
        checkOutput({tag, "_flags"}, {14'd0, dz, inv}, {14'd0, exp_dz, exp_inv});
        checkOutput({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    endtask

    logic [15:0] rq;
    logic        rdz, rinv;
    int          rlat;
    logic        saw_done;
    logic [15:0] rne_expect;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        float1 = 16'h0000;
        float2 = 16'h0000;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {quotient[11:0], busy, done, div_zero, invalid}, 16'h0000);
        checkOutput("reset_quotient", quotient, 16'h0000);
        rst = 1'b0;

        runVector("two_by_one", 16'h4000, 16'h3C00, 16'h4000, 1'b0, 1'b0, 16);
        @(negedge clk);
        checkOutput("after_done", {14'd0, busy, done}, 16'd0);

`ifdef HALF_FP_DIV_RNE_EN
        rne_expect = 16'h3C01;
`else
        rne_expect = 16'h3C00;
`endif
        runVector("round_case", 16'h3C00, 16'h3BFF, rne_expect, 1'b0, 1'b0, 16);
        runVector("one_third", 16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 16);
        runVector("half", 16'h3C00, 16'h4000, 16'h3800, 1'b0, 1'b0, 16);
        runVector("neg", 16'hC000, 16'h4000, 16'hBC00, 1'b0, 1'b0, 16);
        runVector("overflow", 16'h7BFF, 16'h0400, 16'h7C00, 1'b0, 1'b0, 16);
        runVector("underflow", 16'h0400, 16'h7BFF, 16'h0000, 1'b0, 1'b0, 16);

        runVector("div_by_zero", 16'h3C00, 16'h0000, 16'h7C00, 1'b1, 1'b0, 2);
        runVector("neg_div_zero", 16'hBC00, 16'h0000, 16'hFC00, 1'b1, 1'b0, 2);
        runVector("zero_zero", 16'h0000, 16'h0000, 16'h7E00, 1'b0, 1'b1, 2);
        runVector("subn_zero", 16'h0001, 16'h0000, 16'h7E00, 1'b0, 1'b1, 2);
        runVector("nan_in", 16'hFE00, 16'h3C00, 16'h7E00, 1'b0, 1'b1, 2);
        runVector("inf_inf", 16'h7C00, 16'h7C00, 16'h7E00, 1'b0, 1'b1, 2);
        runVector("inf_x", 16'h7C00, 16'hC000, 16'hFC00, 1'b0, 1'b0, 2);
        runVector("zero_x", 16'h8000, 16'h3C00, 16'h8000, 1'b0, 1'b0, 2);
        runVector("x_inf", 16'h3C00, 16'hFC00, 16'h8000, 1'b0, 1'b0, 2);

        // A second start while busy must not disturb the running divide.
        @(negedge clk);
        float1 = 16'h4000;
        float2 = 16'h3C00;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rlat  = 1;
        checkOutput("busy_cycle1", {15'd0, busy}, 16'd1);
        repeat (3) begin
            @(negedge clk);
            rlat++;
        end
        float1 = 16'h3C00;
        float2 = 16'h0000;
        start  = 1'b1;
        @(negedge clk);
        rlat++;
        start = 1'b0;
        while (!done && rlat < 40) begin
            @(negedge clk);
            rlat++;
        end
        checkOutput("ignore_start_q", quotient, 16'h4000);
        checkOutput("ignore_start_dz", {15'd0, div_zero}, 16'd0);
        checkOutput("ignore_start_lat", 16'(rlat), 16'd16);

        // Reset in the middle of DIVIDE aborts without a done pulse.
        @(negedge clk);
        float1 = 16'h4000;
        float2 = 16'h3C00;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_outputs", {quotient[11:0], busy, done, div_zero, invalid}, 16'h0000);
        checkOutput("abort_quotient", quotient, 16'h0000);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", {15'd0, saw_done}, 16'd0);

        runVector("after_reset", 16'h4200, 16'h3C00, 16'h4200, 1'b0, 1'b0, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
